// File: rtl/matmul_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matmul_operand_sequencer
// Function : Walks C[i][j] = sum_k A[i][k]*B[k][j] (i outer, k inner) and streams
//            (A,B) operand pairs with first/last markers to the MAC stage.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_operand_sequencer #(
    parameter int ADDR_W = 18,
    parameter int DIM_W  = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DIM_W-1:0]  dim_m_i,
    input  logic [DIM_W-1:0]  dim_k_i,
    input  logic [DIM_W-1:0]  dim_n_i,
    input  logic              a_loaded_i,
    input  logic              b_loaded_i,
    output logic              a_rd_en_o,
    output logic [ADDR_W-1:0] a_rd_addr_o,
    input  logic [DATA_W-1:0] a_rd_data_i,
    output logic              b_rd_en_o,
    output logic [ADDR_W-1:0] b_rd_addr_o,
    input  logic [DATA_W-1:0] b_rd_data_i,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic              op_first_o,
    output logic              op_last_o,
    output logic [DIM_W-1:0]  op_row_o,
    output logic [DIM_W-1:0]  op_col_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [DIM_W-1:0]    dim_m_q, dim_k_q, dim_n_q;
    logic [DIM_W-1:0]    cnt_i_q, cnt_j_q, cnt_k_q;
    logic [ADDR_W-1:0]   a_base_q, a_addr_q, b_addr_q;
    logic                busy_q, done_q;

    logic                infl_q, infl_first_q, infl_last_q;
    logic [DIM_W-1:0]    infl_row_q, infl_col_q;

    logic [DATA_W-1:0]   fifo_a_q     [2];
    logic [DATA_W-1:0]   fifo_b_q     [2];
    logic                fifo_first_q [2];
    logic                fifo_last_q  [2];
    logic [DIM_W-1:0]    fifo_row_q   [2];
    logic [DIM_W-1:0]    fifo_col_q   [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          count_q;

    logic w_pop, w_credit, w_issue, w_start_ok, w_zero_dim;
    logic w_k_last, w_j_last, w_i_last, w_drained;

    assign w_pop      = op_valid_o && op_ready_i;
    // Slots already committed (stored + returning) minus the one leaving this cycle.
    assign w_credit   = ({1'b0, count_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, w_pop});
    assign w_issue    = (state_q == S_RUN) && w_credit;
    assign w_start_ok = start_i && a_loaded_i && b_loaded_i;
    assign w_zero_dim = (dim_m_i == '0) || (dim_k_i == '0) || (dim_n_i == '0);
    assign w_k_last   = (cnt_k_q == dim_k_q - DIM_W'(1));
    assign w_j_last   = (cnt_j_q == dim_n_q - DIM_W'(1));
    assign w_i_last   = (cnt_i_q == dim_m_q - DIM_W'(1));
    assign w_drained  = !infl_q && ((count_q == 2'd0) || ((count_q == 2'd1) && w_pop));

    assign a_rd_en_o   = w_issue;
    assign b_rd_en_o   = w_issue;
    assign a_rd_addr_o = a_addr_q;
    assign b_rd_addr_o = b_addr_q;

    assign op_valid_o = (count_q != 2'd0);
    assign op_a_o     = fifo_a_q[rd_ptr_q];
    assign op_b_o     = fifo_b_q[rd_ptr_q];
    assign op_first_o = fifo_first_q[rd_ptr_q];
    assign op_last_o  = fifo_last_q[rd_ptr_q];
    assign op_row_o   = fifo_row_q[rd_ptr_q];
    assign op_col_o   = fifo_col_q[rd_ptr_q];
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dim_m_q  <= '0;
            dim_k_q  <= '0;
            dim_n_q  <= '0;
            cnt_i_q  <= '0;
            cnt_j_q  <= '0;
            cnt_k_q  <= '0;
            a_base_q <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_start_ok) begin
                        dim_m_q  <= dim_m_i;
                        dim_k_q  <= dim_k_i;
                        dim_n_q  <= dim_n_i;
                        cnt_i_q  <= '0;
                        cnt_j_q  <= '0;
                        cnt_k_q  <= '0;
                        a_base_q <= '0;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                        if (w_zero_dim) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        // Incremental address walk: k steps add 1 / N, j and i steps rewind.
                        if (!w_k_last) begin
                            cnt_k_q  <= cnt_k_q + DIM_W'(1);
                            a_addr_q <= a_addr_q + ADDR_W'(1);
                            b_addr_q <= b_addr_q + ADDR_W'(dim_n_q);
                        end else if (!w_j_last) begin
                            cnt_k_q  <= '0;
                            cnt_j_q  <= cnt_j_q + DIM_W'(1);
                            a_addr_q <= a_base_q;
                            b_addr_q <= ADDR_W'(cnt_j_q) + ADDR_W'(1);
                        end else if (!w_i_last) begin
                            cnt_k_q  <= '0;
                            cnt_j_q  <= '0;
                            cnt_i_q  <= cnt_i_q + DIM_W'(1);
                            a_base_q <= a_base_q + ADDR_W'(dim_k_q);
                            a_addr_q <= a_base_q + ADDR_W'(dim_k_q);
                            b_addr_q <= '0;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q       <= 1'b0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
            infl_row_q   <= '0;
            infl_col_q   <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            for (int e = 0; e < 2; e++) begin
                fifo_a_q[e]     <= '0;
                fifo_b_q[e]     <= '0;
                fifo_first_q[e] <= 1'b0;
                fifo_last_q[e]  <= 1'b0;
                fifo_row_q[e]   <= '0;
                fifo_col_q[e]   <= '0;
            end
        end else begin
            infl_q <= w_issue;
            if (w_issue) begin
                infl_first_q <= (cnt_k_q == '0);
                infl_last_q  <= w_k_last;
                infl_row_q   <= cnt_i_q;
                infl_col_q   <= cnt_j_q;
            end
            if (infl_q) begin
                fifo_a_q[wr_ptr_q]     <= a_rd_data_i;
                fifo_b_q[wr_ptr_q]     <= b_rd_data_i;
                fifo_first_q[wr_ptr_q] <= infl_first_q;
                fifo_last_q[wr_ptr_q]  <= infl_last_q;
                fifo_row_q[wr_ptr_q]   <= infl_row_q;
                fifo_col_q[wr_ptr_q]   <= infl_col_q;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({infl_q, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire
